idecode_pipe: RTL and testbench

//  Parametrised decode stage: ISA field extraction, 2R/1W register file, per-register scoreboard
//  and a registered ID/EX output with valid/ready handshake. Sits between the IF/ID latch and execute.

---
 rtl/idecode_pkg.sv | 54 +++++
 rtl/idecode_pipe_sb.sv | 55 +++++
 rtl/idecode_pipe.sv | 156 +++++++++++++++
 tb/tb_idecode_pipe.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idecode_pkg.sv
// Decode-stage ISA definitions: field positions, opcodes, decode classes and the decode() table.
package idecode_pkg;

  localparam int OP_MSB = 15, OP_LSB = 11;
  localparam int RS_MSB = 10, RS_LSB = 8;
  localparam int RT_MSB = 7,  RT_LSB = 5;
  localparam int RD_MSB = 4,  RD_LSB = 2;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_ADDI = 5'd3;
  localparam logic [4:0] OP_ORI  = 5'd4;
  localparam logic [4:0] OP_LUI  = 5'd5;
  localparam logic [4:0] OP_LW   = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_BEQ  = 5'd8;
  localparam logic [4:0] OP_JAL  = 5'd9;
  localparam logic [4:0] OP_JR   = 5'd10;

  typedef enum logic [2:0] {IMM_NONE, IMM_S5, IMM_Z5, IMM_Z8, IMM_S11} imm_kind_e;
  typedef enum logic [1:0] {DST_RT, DST_RS, DST_RD, DST_R7} dst_sel_e;

  typedef struct packed {
    logic      uses_rs;
    logic      uses_rt;
    logic      wen;
    logic      illegal;
    dst_sel_e  dst_sel;
    imm_kind_e imm_kind;
  } decode_t;

  // Illegal opcodes come back with no reads and no write so they never touch the scoreboard.
  function automatic decode_t decode(input logic [4:0] op);
    decode_t d;
    d = '{uses_rs: 1'b0, uses_rt: 1'b0, wen: 1'b0, illegal: 1'b0,
          dst_sel: DST_RD, imm_kind: IMM_NONE};
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB: begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.wen = 1'b1; end
      OP_ADDI, OP_LW: begin
        d.uses_rs = 1'b1; d.wen = 1'b1; d.dst_sel = DST_RT; d.imm_kind = IMM_S5;
      end
      OP_ORI: begin d.uses_rs = 1'b1; d.wen = 1'b1; d.dst_sel = DST_RT; d.imm_kind = IMM_Z5; end
      OP_LUI: begin d.wen = 1'b1; d.dst_sel = DST_RS; d.imm_kind = IMM_Z8; end
      OP_SW, OP_BEQ: begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.imm_kind = IMM_S5; end
      OP_JAL: begin d.wen = 1'b1; d.dst_sel = DST_R7; d.imm_kind = IMM_S11; end
      OP_JR: d.uses_rs = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/idecode_pipe_sb.sv
// Per-register in-flight writer counters; issue increments, retire and flush of the ID/EX entry decrement.
module idecode_sb #(
  parameter int NUM_REGS     = 8,
  parameter int MAX_INFLIGHT = 4,
  parameter int REG_AW       = $clog2(NUM_REGS),
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_inc,
  input  logic [REG_AW-1:0]   i_inc_idx,
  input  logic                i_dec,
  input  logic [REG_AW-1:0]   i_dec_idx,
  input  logic                i_fdec,
  input  logic [REG_AW-1:0]   i_fdec_idx,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [NUM_REGS-1:0] o_full,
  output logic [NUM_REGS-1:0] o_last
);

  logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt, w_nxt;
  logic [NUM_REGS-1:0][CNT_W+1:0] w_add, w_sub;
  logic [NUM_REGS-1:0]            w_ok;

  // Two extra bits so inc and a double decrement resolve without wrapping.
  always_comb begin
    w_nxt  = r_cnt;
    w_add  = '0;
    w_sub  = '0;
    w_ok   = '1;
    o_busy = '0;
    o_full = '0;
    o_last = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_add[i]  = {2'b00, r_cnt[i]} + (CNT_W+2)'(i_inc && i_inc_idx == REG_AW'(i));
      w_sub[i]  = (CNT_W+2)'(i_dec && i_dec_idx == REG_AW'(i))
                + (CNT_W+2)'(i_fdec && i_fdec_idx == REG_AW'(i));
      w_ok[i]   = (w_sub[i] <= w_add[i]) &&
                  ((w_add[i] - w_sub[i]) <= (CNT_W+2)'(MAX_INFLIGHT));
      w_nxt[i]  = CNT_W'(w_add[i] - w_sub[i]);
      o_busy[i] = r_cnt[i] != '0;
      o_full[i] = r_cnt[i] == CNT_W'(MAX_INFLIGHT);
      o_last[i] = r_cnt[i] == CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_nxt;
  end

  // Retiring a writer that was never issued (or overfilling) is an upstream protocol error.
  assert property (@(posedge clk) disable iff (rst) &w_ok);

endmodule

// File: rtl/idecode_pipe.sv
// Decode stage: field decode, 2R/1W register file, RAW scoreboard and ID/EX register.
// Define IDECODE_WB_BYPASS_EN to forward write-back data and issue in the retire cycle.
module idecode_pipe
  import idecode_pkg::*;
#(
  parameter  int DATA_W       = 16,
  parameter  int INSTR_W      = 16,
  parameter  int NUM_REGS     = 8,
  parameter  int MAX_INFLIGHT = 4,
  localparam int REG_AW       = $clog2(NUM_REGS),
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [4:0]         ex_opcode,
  output logic [REG_AW-1:0]  ex_dst,
  output logic               ex_wen,
  output logic               ex_err,
  input  logic               wb_retire,
  input  logic               wb_wen,
  input  logic [REG_AW-1:0]  wb_dst,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               hazard_stall
);

  logic [4:0]                     w_op;
  logic [REG_AW-1:0]              w_rs, w_rt, w_rd, w_dst;
  decode_t                        w_dec;
  logic [DATA_W-1:0]              w_imm, w_rs_data, w_rt_data;
  logic                           w_wb, w_xfer, w_rs_busy, w_rt_busy;
  logic [NUM_REGS-1:0]            w_busy, w_full, w_last;
  logic [NUM_REGS-1:0][DATA_W-1:0] r_rf;

  logic               r_ex_valid, r_ex_wen, r_ex_err;
  logic [DATA_W-1:0]  r_ex_pc, r_ex_rs, r_ex_rt, r_ex_imm;
  logic [4:0]         r_ex_op;
  logic [REG_AW-1:0]  r_ex_dst;

  assign w_op  = id_instr[OP_MSB:OP_LSB];
  assign w_rs  = REG_AW'(id_instr[RS_MSB:RS_LSB]);
  assign w_rt  = REG_AW'(id_instr[RT_MSB:RT_LSB]);
  assign w_rd  = REG_AW'(id_instr[RD_MSB:RD_LSB]);
  assign w_dec = decode(w_op);
  assign w_wb  = wb_retire & wb_wen;

  always_comb begin
    w_dst = w_rd;
    case (w_dec.dst_sel)
      DST_RT:  w_dst = w_rt;
      DST_RS:  w_dst = w_rs;
      DST_R7:  w_dst = REG_AW'(NUM_REGS - 1);
      default: w_dst = w_rd;
    endcase
  end

  always_comb begin
    w_imm = '0;
    case (w_dec.imm_kind)
      IMM_S5:  w_imm = {{(DATA_W-5){id_instr[4]}}, id_instr[4:0]};
      IMM_Z5:  w_imm = DATA_W'(id_instr[4:0]);
      IMM_Z8:  w_imm = DATA_W'(id_instr[7:0]);
      IMM_S11: w_imm = {{(DATA_W-11){id_instr[10]}}, id_instr[10:0]};
      default: w_imm = '0;
    endcase
  end

`ifdef IDECODE_WB_BYPASS_EN
  // Last outstanding writer retiring this cycle: forward its data instead of stalling.
  assign w_rs_busy = w_busy[w_rs] & ~(w_wb && wb_dst == w_rs && w_last[w_rs]);
  assign w_rt_busy = w_busy[w_rt] & ~(w_wb && wb_dst == w_rt && w_last[w_rt]);
  assign w_rs_data = (w_wb && wb_dst == w_rs) ? wb_data : r_rf[w_rs];
  assign w_rt_data = (w_wb && wb_dst == w_rt) ? wb_data : r_rf[w_rt];
`else
  assign w_rs_busy = w_busy[w_rs];
  assign w_rt_busy = w_busy[w_rt];
  assign w_rs_data = r_rf[w_rs];
  assign w_rt_data = r_rf[w_rt];
`endif

  assign hazard_stall = id_valid & ((w_dec.uses_rs & w_rs_busy) |
                                    (w_dec.uses_rt & w_rt_busy) |
                                    (w_dec.wen & w_full[w_dst]));
  assign id_ready = flush | (~hazard_stall & (~r_ex_valid | ex_ready));
  assign w_xfer   = id_valid & id_ready & ~flush;

  idecode_sb #(
    .NUM_REGS(NUM_REGS), .MAX_INFLIGHT(MAX_INFLIGHT), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_xfer & w_dec.wen),
    .i_inc_idx  (w_dst),
    .i_dec      (w_wb),
    .i_dec_idx  (wb_dst),
    .i_fdec     (flush & r_ex_valid & r_ex_wen),
    .i_fdec_idx (r_ex_dst),
    .o_busy     (w_busy),
    .o_full     (w_full),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst)       r_rf <= '0;
    else if (w_wb) r_rf[wb_dst] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_wen   <= 1'b0;
      r_ex_err   <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_imm   <= '0;
      r_ex_op    <= '0;
      r_ex_dst   <= '0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_xfer) begin
      r_ex_valid <= 1'b1;
      r_ex_wen   <= w_dec.wen;
      r_ex_err   <= w_dec.illegal;
      r_ex_pc    <= id_pc;
      r_ex_rs    <= w_rs_data;
      r_ex_rt    <= w_rt_data;
      r_ex_imm   <= w_imm;
      r_ex_op    <= w_op;
      r_ex_dst   <= w_dec.illegal ? '0 : w_dst;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_wen     = r_ex_wen;
  assign ex_err     = r_ex_err;
  assign ex_pc      = r_ex_pc;
  assign ex_rs_data = r_ex_rs;
  assign ex_rt_data = r_ex_rt;
  assign ex_imm     = r_ex_imm;
  assign ex_opcode  = r_ex_op;
  assign ex_dst     = r_ex_dst;

endmodule

// File: tb/tb_idecode_pipe.sv
// Directed hazard/flush/reset scenarios plus a randomized run against a cycle-level ISA model.
`timescale 1ns/1ps
module tb_idecode_pipe;

  localparam int T_NOP = 0, T_ADD = 1, T_SUB = 2, T_ADDI = 3, T_ORI = 4, T_LUI = 5;
  localparam int T_LW = 6, T_SW = 7, T_BEQ = 8, T_JAL = 9, T_JR = 10, T_BAD = 31;
`ifdef IDECODE_WB_BYPASS_EN
  localparam int EXP_STALL = 2;
  localparam bit BYP = 1'b1;
`else
  localparam int EXP_STALL = 3;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst;
  logic        id_valid, id_ready, flush, ex_valid, ex_ready, ex_wen, ex_err;
  logic        wb_retire, wb_wen, hazard_stall;
  logic [15:0] id_instr, id_pc, ex_pc, ex_rs_data, ex_rt_data, ex_imm, wb_data;
  logic [4:0]  ex_opcode;
  logic [2:0]  ex_dst, wb_dst;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  idecode_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_opcode(ex_opcode),
    .ex_dst(ex_dst), .ex_wen(ex_wen), .ex_err(ex_err), .wb_retire(wb_retire), .wb_wen(wb_wen),
    .wb_dst(wb_dst), .wb_data(wb_data), .hazard_stall(hazard_stall)
  );

  typedef struct packed {
    logic        urs, urt, wen, ill;
    logic [2:0]  dst;
    logic [15:0] imm;
  } tdec_t;

  typedef struct {
    int          dst;
    bit          wen;
    logic [15:0] data;
    int          due;
  } ret_t;

  function automatic logic [15:0] ri(input int op, input int rs, input int rt, input int imm);
    return {op[4:0], rs[2:0], rt[2:0], imm[4:0]};
  endfunction

  function automatic logic [15:0] rr(input int op, input int rs, input int rt, input int rd);
    return {op[4:0], rs[2:0], rt[2:0], rd[2:0], 2'b00};
  endfunction

  // ISA table: what each opcode reads, writes and how its immediate is formed.
  function automatic tdec_t tdec(input logic [15:0] ins);
    tdec_t d;
    int op;
    d = '0;
    op = int'(ins[15:11]);
    case (op)
      T_NOP: ;
      T_ADD, T_SUB: begin d.urs = 1; d.urt = 1; d.wen = 1; d.dst = ins[4:2]; end
      T_ADDI, T_LW: begin d.urs = 1; d.wen = 1; d.dst = ins[7:5]; d.imm = {{11{ins[4]}}, ins[4:0]}; end
      T_ORI: begin d.urs = 1; d.wen = 1; d.dst = ins[7:5]; d.imm = {11'd0, ins[4:0]}; end
      T_LUI: begin d.wen = 1; d.dst = ins[10:8]; d.imm = {8'd0, ins[7:0]}; end
      T_SW, T_BEQ: begin d.urs = 1; d.urt = 1; d.imm = {{11{ins[4]}}, ins[4:0]}; end
      T_JAL: begin d.wen = 1; d.dst = 3'd7; d.imm = {{5{ins[10]}}, ins[10:0]}; end
      T_JR: d.urs = 1;
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  task automatic idle();
    id_valid = 0; id_instr = '0; id_pc = '0; flush = 0; ex_ready = 1;
    wb_retire = 0; wb_wen = 0; wb_dst = '0; wb_data = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    @(posedge clk); @(negedge clk);
    total++;
    if ({ex_valid, ex_err, ex_wen, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_opcode, ex_dst} !== '0) begin
      bad++; $display("FAIL reset_ex got v=%b err=%b pc=%h imm=%h exp all zero", ex_valid, ex_err, ex_pc, ex_imm);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    total++;
    if (id_ready !== 1'b1 || hazard_stall !== 1'b0) begin
      bad++; $display("FAIL reset_ready got rdy=%b hz=%b exp rdy=1 hz=0", id_ready, hazard_stall);
    end
    step();
  endtask

  task automatic test_raw();
    int stalls = 0;
    bit acc = 0;
    do_reset();
    id_valid = 1; id_instr = ri(T_ADDI, 0, 1, 5); id_pc = 16'h0002;
    @(negedge clk);
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL raw_first_rdy got=%b exp=1", id_ready); end
    step();
    id_instr = rr(T_ADD, 1, 1, 2); id_pc = 16'h0004;
    for (int k = 0; k < 10 && !acc; k++) begin
      wb_retire = (k == 2); wb_wen = (k == 2); wb_dst = 3'd1; wb_data = 16'd5;
      @(negedge clk);
      if (hazard_stall) stalls++;
      acc = id_ready;
      step();
    end
    id_valid = 0; wb_retire = 0; wb_wen = 0;
    total++;
    if (!acc || stalls != EXP_STALL) begin
      bad++; $display("FAIL raw_stalls got stalls=%0d acc=%0d exp stalls=%0d acc=1", stalls, acc, EXP_STALL);
    end
    @(negedge clk);
    total++;
    if (ex_valid !== 1 || ex_rs_data !== 16'd5 || ex_rt_data !== 16'd5 || ex_dst !== 3'd2 || ex_wen !== 1) begin
      bad++; $display("FAIL raw_operands got v=%b rs=%h rt=%h dst=%0d exp v=1 rs=5 rt=5 dst=2", ex_valid, ex_rs_data, ex_rt_data, ex_dst);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    id_valid = 1; id_instr = ri(T_ADDI, 0, 1, 5); id_pc = 16'h0002;
    step();
    id_instr = ri(T_ADDI, 0, 2, 7); id_pc = 16'h0004; ex_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (id_ready !== 0 || hazard_stall !== 0) begin
        bad++; $display("FAIL bp_ready k=%0d got rdy=%b hz=%b exp rdy=0 hz=0", k, id_ready, hazard_stall);
      end
      total++;
      if ({ex_valid, ex_pc, ex_imm, ex_dst, ex_opcode, ex_wen} !== {1'b1, 16'h0002, 16'd5, 3'd1, 5'd3, 1'b1}) begin
        bad++; $display("FAIL bp_hold k=%0d got v=%b pc=%h imm=%h dst=%0d exp v=1 pc=0002 imm=0005 dst=1", k, ex_valid, ex_pc, ex_imm, ex_dst);
      end
      step();
    end
    ex_ready = 1;
    @(negedge clk);
    total++;
    if (id_ready !== 1) begin bad++; $display("FAIL bp_release got rdy=%b exp=1", id_ready); end
    step();
    id_valid = 0; wb_retire = 1; wb_wen = 1; wb_dst = 3'd1; wb_data = 16'd5;
    @(negedge clk);
    total++;
    if (ex_imm !== 16'd7 || ex_dst !== 3'd2) begin
      bad++; $display("FAIL bp_second got imm=%h dst=%0d exp imm=0007 dst=2", ex_imm, ex_dst);
    end
    step();
    wb_retire = 0; wb_wen = 0; id_valid = 1; id_instr = rr(T_ADD, 1, 1, 3);
    @(negedge clk);
    total++;
    if (hazard_stall !== 0) begin bad++; $display("FAIL bp_cnt got hz=%b exp=0", hazard_stall); end
    step();
    id_valid = 0;
  endtask

  task automatic test_full();
    do_reset();
    id_valid = 1;
    for (int k = 0; k < 4; k++) begin
      id_instr = ri(T_ADDI, 0, 3, k);
      @(negedge clk);
      total++;
      if (id_ready !== 1) begin bad++; $display("FAIL full_fill k=%0d got rdy=%b exp=1", k, id_ready); end
      step();
    end
    id_instr = ri(T_ADDI, 0, 3, 9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (hazard_stall !== 1 || id_ready !== 0) begin
        bad++; $display("FAIL full_stall k=%0d got hz=%b rdy=%b exp hz=1 rdy=0", k, hazard_stall, id_ready);
      end
      step();
    end
    wb_retire = 1; wb_wen = 1; wb_dst = 3'd3; wb_data = 16'd0;
    @(negedge clk);
    total++;
    if (hazard_stall !== 1) begin bad++; $display("FAIL full_retire_cycle got hz=%b exp=1", hazard_stall); end
    step();
    wb_retire = 0; wb_wen = 0;
    @(negedge clk);
    total++;
    if (hazard_stall !== 0 || id_ready !== 1) begin
      bad++; $display("FAIL full_release got hz=%b rdy=%b exp hz=0 rdy=1", hazard_stall, id_ready);
    end
    step();
    id_valid = 0;
    @(negedge clk);
    total++;
    if (ex_valid !== 1 || ex_imm !== 16'd9) begin
      bad++; $display("FAIL full_issue got v=%b imm=%h exp v=1 imm=0009", ex_valid, ex_imm);
    end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    id_valid = 1; id_instr = ri(T_ADDI, 0, 4, 1);
    step();
    id_instr = ri(T_ADDI, 0, 4, 2);
    step();
    ex_ready = 0; flush = 1; wb_retire = 1; wb_wen = 1; wb_dst = 3'd4; wb_data = 16'h0009;
    id_instr = rr(T_ADD, 4, 4, 5); id_pc = 16'h0040;
    @(negedge clk);
    total++;
    if (id_ready !== 1 || ex_valid !== 1) begin
      bad++; $display("FAIL flush_cycle got rdy=%b v=%b exp rdy=1 v=1", id_ready, ex_valid);
    end
    step();
    flush = 0; wb_retire = 0; wb_wen = 0; ex_ready = 1;
    @(negedge clk);
    total++;
    if (ex_valid !== 0 || hazard_stall !== 0) begin
      bad++; $display("FAIL flush_after got v=%b hz=%b exp v=0 hz=0", ex_valid, hazard_stall);
    end
    step();
    id_valid = 0;
    @(negedge clk);
    total++;
    if (ex_valid !== 1 || ex_rs_data !== 16'h0009 || ex_pc !== 16'h0040) begin
      bad++; $display("FAIL flush_reissue got v=%b rs=%h pc=%h exp v=1 rs=0009 pc=0040", ex_valid, ex_rs_data, ex_pc);
    end
    step();
  endtask

  task automatic test_illegal();
    do_reset();
    id_valid = 1; id_instr = rr(T_BAD, 1, 2, 3); id_pc = 16'h0010;
    @(negedge clk);
    total++;
    if (hazard_stall !== 0 || id_ready !== 1) begin
      bad++; $display("FAIL ill_accept got hz=%b rdy=%b exp hz=0 rdy=1", hazard_stall, id_ready);
    end
    step();
    id_instr = rr(T_ADD, 3, 2, 3);
    @(negedge clk);
    total++;
    if (ex_valid !== 1 || ex_err !== 1 || ex_wen !== 0 || ex_opcode !== 5'd31) begin
      bad++; $display("FAIL ill_entry got v=%b err=%b wen=%b op=%0d exp v=1 err=1 wen=0 op=31", ex_valid, ex_err, ex_wen, ex_opcode);
    end
    total++;
    if (hazard_stall !== 0) begin bad++; $display("FAIL ill_no_inc got hz=%b exp=0", hazard_stall); end
    step();
    id_valid = 0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    id_valid = 1; id_instr = ri(T_ADDI, 0, 1, 3);
    step();
    id_valid = 0; wb_retire = 1; wb_wen = 1; wb_dst = 3'd1; wb_data = 16'h0055;
    step();
    wb_retire = 0; wb_wen = 0; id_valid = 1; id_instr = ri(T_ADDI, 0, 2, 3);
    step();
    ex_ready = 0; id_instr = rr(T_ADD, 1, 2, 3); id_pc = 16'h0020;
    @(negedge clk);
    total++;
    if (ex_valid !== 1 || hazard_stall !== 1) begin
      bad++; $display("FAIL rstmid_pre got v=%b hz=%b exp v=1 hz=1", ex_valid, hazard_stall);
    end
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    total++;
    if (ex_valid !== 0 || ex_err !== 0 || hazard_stall !== 0 || id_ready !== 1) begin
      bad++; $display("FAIL rstmid_post got v=%b err=%b hz=%b rdy=%b exp v=0 err=0 hz=0 rdy=1", ex_valid, ex_err, hazard_stall, id_ready);
    end
    step();
    id_valid = 0;
    @(negedge clk);
    total++;
    if (ex_valid !== 1 || ex_rs_data !== 16'd0 || ex_rt_data !== 16'd0) begin
      bad++; $display("FAIL rstmid_rf got v=%b rs=%h rt=%h exp v=1 rs=0 rt=0", ex_valid, ex_rs_data, ex_rt_data);
    end
    step();
  endtask

  task automatic test_random();
    logic [15:0] m_regs[8];
    int          m_cnt[8];
    ret_t        rq[$];
    ret_t        r;
    bit          m_v, m_wen, m_err;
    logic [15:0] m_pc, m_rs, m_rt, m_imm;
    logic [4:0]  m_op;
    logic [2:0]  m_dst, rs, rt;
    logic [15:0] rd_rs, rd_rt;
    tdec_t       d;
    bit          wbw, brs, brt, e_hz, e_rdy, xfer;
    int          sel;
    do_reset();
    for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_cnt[i] = 0; end
    m_v = 0; m_wen = 0; m_err = 0; m_pc = '0; m_rs = '0; m_rt = '0; m_imm = '0; m_op = '0; m_dst = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      sel = int'($urandom_range(11));
      id_valid = ($urandom_range(3) != 0);
      id_instr = {(sel == 11) ? 5'd31 : 5'(sel), 11'($urandom)};
      id_pc    = 16'($urandom);
      ex_ready = ($urandom_range(9) < 7);
      flush    = ($urandom_range(19) == 0);
      wb_retire = 0; wb_wen = 0; wb_dst = '0; wb_data = '0;
      if (rq.size() > 0 && rq[0].due <= cyc && $urandom_range(3) != 0) begin
        r = rq.pop_front();
        wb_retire = 1; wb_wen = r.wen; wb_dst = 3'(r.dst); wb_data = r.data;
      end
      d  = tdec(id_instr);
      rs = id_instr[10:8];
      rt = id_instr[7:5];
      wbw = wb_retire && wb_wen;
      brs = m_cnt[rs] != 0;
      brt = m_cnt[rt] != 0;
      rd_rs = m_regs[rs];
      rd_rt = m_regs[rt];
      if (BYP && wbw) begin
        if (wb_dst == rs && m_cnt[rs] == 1) brs = 0;
        if (wb_dst == rt && m_cnt[rt] == 1) brt = 0;
        if (wb_dst == rs) rd_rs = wb_data;
        if (wb_dst == rt) rd_rt = wb_data;
      end
      e_hz  = id_valid && ((d.urs && brs) || (d.urt && brt) || (d.wen && m_cnt[d.dst] == 4));
      e_rdy = flush || (!e_hz && (!m_v || ex_ready));
      xfer  = id_valid && e_rdy && !flush;

      @(negedge clk);
      total++;
      if (hazard_stall !== e_hz) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, hazard_stall, e_hz); end
      total++;
      if (id_ready !== e_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, id_ready, e_rdy); end
      total++;
      if (ex_valid !== m_v) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, ex_valid, m_v); end
      if (m_v) begin
        total++;
        if ({ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_opcode} !== {m_pc, m_rs, m_rt, m_imm, m_op}) begin
          bad++; $display("FAIL rnd_data cyc=%0d got pc=%h rs=%h rt=%h imm=%h op=%0d exp pc=%h rs=%h rt=%h imm=%h op=%0d",
                          cyc, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_opcode, m_pc, m_rs, m_rt, m_imm, m_op);
        end
        total++;
        if (ex_err !== m_err || ex_wen !== m_wen || (m_wen && ex_dst !== m_dst)) begin
          bad++; $display("FAIL rnd_ctl cyc=%0d got err=%b wen=%b dst=%0d exp err=%b wen=%b dst=%0d",
                          cyc, ex_err, ex_wen, ex_dst, m_err, m_wen, m_dst);
        end
      end

      if (m_v && ex_ready && !flush)
        rq.push_back('{dst: int'(m_dst), wen: m_wen, data: 16'($urandom), due: cyc + 1 + int'($urandom_range(4))});
      if (xfer && d.wen) m_cnt[d.dst]++;
      if (wbw) begin m_cnt[wb_dst]--; m_regs[wb_dst] = wb_data; end
      if (flush && m_v && m_wen) m_cnt[m_dst]--;
      if (flush) m_v = 0;
      else if (xfer) begin
        m_v = 1; m_pc = id_pc; m_rs = rd_rs; m_rt = rd_rt; m_imm = d.imm;
        m_op = id_instr[15:11]; m_wen = d.wen; m_err = d.ill; m_dst = d.dst;
      end else if (ex_ready) m_v = 0;
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_backpressure();
    test_full();
    test_flush();
    test_illegal();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
